// File: rtl/activation_stage.sv
// ---------------------------------------------------------------------------
// activation_stage
//
// Applies a per-lane activation function to row vectors coming out of the
// norm stage. The result goes to the BRAM C write-back flop. Latency is a
// fixed two cycles. The interface is strobe-based and stall-free, so there
// is no backpressure. The stage counts rows and pulses done_activation once
// the last row of a matrix has left the pipeline.
//
// Handshake: a row is transferred in any cycle where its valid strobe
// (in_data_available / out_data_available) is high. There is no ready, so
// the consumer must take every row in the cycle it is presented.
//
// Ports
//   clk                 clock
//   reset               synchronous, active-high reset
//   enable_activation   0 = bypass (data passes unchanged, same latency)
//   mode                00 bypass, 01 ReLU, 10 clamped ReLU, 11 leaky ReLU
//   clamp_max           signed upper bound for clamped ReLU
//   leak_shift          arithmetic right-shift for negative lanes (leaky)
//   num_rows            rows per matrix, 0 means 256
//   in_data_available   inp_data valid this cycle
//   inp_data            input row, lane i at [i*DWIDTH +: DWIDTH]
//   out_data            activated row, 0 whenever out_data_available is 0
//   out_data_available  out_data valid this cycle
//   done_activation     1-cycle pulse when the matrix is complete
//   busy                high from the first accepted row until the done pulse
//
// The FSM state is held in the internal signal 'state' so that checkers can
// bind to it.
// ---------------------------------------------------------------------------
module activation_stage #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable_activation,
    input  logic [1:0]                     mode,
    input  logic [DWIDTH-1:0]              clamp_max,
    input  logic [2:0]                     leak_shift,
    input  logic [7:0]                     num_rows,
    input  logic                           in_data_available,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
    output logic                           out_data_available,
    output logic                           done_activation,
    output logic                           busy
);

    localparam int RW = MAT_MUL_SIZE * DWIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Configuration captured when a matrix starts.
    logic              en_q;
    logic [1:0]        mode_q;
    logic [DWIDTH-1:0] clamp_q;
    logic [2:0]        shift_q;
    logic [8:0]        rows_q;

    // 9-bit counters so that a 256-row matrix does not wrap.
    logic [8:0] in_cnt;
    logic [8:0] out_cnt;
    logic [8:0] in_cnt_inc;
    logic [8:0] out_cnt_seen;
    logic [8:0] rows_live;

    logic          accept;
    logic          s1_valid;
    logic [RW-1:0] s1_data;
    logic [RW-1:0] row_act;

    logic signed [DWIDTH-1:0] clamp_eff;

    // A num_rows of 0 encodes 256 rows.
    assign rows_live  = {(num_rows == 8'd0), num_rows};
    assign in_cnt_inc = in_cnt + 9'd1;
    // Rows already out, including the one on the output this cycle. Using it
    // lets DONE land exactly one cycle after the final output row.
    assign out_cnt_seen = out_cnt + {8'd0, out_data_available};

    // Rows are taken only while a matrix is open. In DRAIN and DONE they are
    // dropped.
    assign accept = in_data_available && ((state == IDLE) || (state == ACTIVE));

    // A negative clamp bound behaves as 0, which forces every lane to 0.
    assign clamp_eff = clamp_q[DWIDTH-1] ? '0 : clamp_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_data_available) begin
                    state_next = (rows_live == 9'd1) ? DRAIN : ACTIVE;
                end
            end
            ACTIVE: begin
                if (in_data_available && (in_cnt_inc == rows_q)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_cnt_seen == rows_q) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        done_activation = (state == DONE);
        busy            = (state == ACTIVE) || (state == DRAIN);
    end

    // ------------------------------------------------------------------
    // Configuration snapshot and row counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q    <= 1'b0;
            mode_q  <= 2'b00;
            clamp_q <= '0;
            shift_q <= 3'd0;
            rows_q  <= 9'd0;
            in_cnt  <= 9'd0;
            out_cnt <= 9'd0;
        end else begin
            if ((state == IDLE) && in_data_available) begin
                en_q    <= enable_activation;
                mode_q  <= mode;
                clamp_q <= clamp_max;
                shift_q <= leak_shift;
                rows_q  <= rows_live;
            end

            if (state == DONE) begin
                in_cnt  <= 9'd0;
                out_cnt <= 9'd0;
            end else begin
                if (state == IDLE && in_data_available) begin
                    in_cnt <= 9'd1;
                end else if (state == ACTIVE && in_data_available) begin
                    in_cnt <= in_cnt_inc;
                end
                if (out_data_available) begin
                    out_cnt <= out_cnt_seen;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane function
    // ------------------------------------------------------------------
    function automatic logic [DWIDTH-1:0] act_lane(
        input logic signed [DWIDTH-1:0] x,
        input logic                     en,
        input logic [1:0]               md,
        input logic signed [DWIDTH-1:0] cm,
        input logic [2:0]               sh
    );
        logic [DWIDTH-1:0] y;
        y = x;
        if (en) begin
            case (md)
                2'b01: begin
                    if (x[DWIDTH-1]) y = '0;
                end
                2'b10: begin
                    if (x[DWIDTH-1]) y = '0;
                    else if (x > cm) y = cm;
                end
                2'b11: begin
                    // Arithmetic shift rounds toward minus infinity.
                    if (x[DWIDTH-1]) y = x >>> sh;
                end
                default: begin
                    y = x;
                end
            endcase
        end
        return y;
    endfunction

    always_comb begin
        row_act = '0;
        for (int i = 0; i < MAT_MUL_SIZE; i++) begin
            row_act[i*DWIDTH +: DWIDTH] = act_lane(s1_data[i*DWIDTH +: DWIDTH],
                                                   en_q, mode_q, clamp_eff, shift_q);
        end
    end

    // ------------------------------------------------------------------
    // Two-stage pipeline: S1 captures the row, S2 registers the result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid           <= 1'b0;
            s1_data            <= '0;
            out_data_available <= 1'b0;
            out_data           <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= inp_data;
            end
            out_data_available <= s1_valid;
            out_data           <= s1_valid ? row_act : '0;
        end
    end

endmodule

// File: tb/tb_activation_stage.sv
// ---------------------------------------------------------------------------
// tb_activation_stage
//
// Directed and randomized stimulus for activation_stage. A reference model
// tracks matrices as timestamps: when each accepted row is due on the output
// and when the done pulse is due. It computes lane results with plain integer
// arithmetic. Every cycle the DUT outputs are compared with the model.
// ---------------------------------------------------------------------------
module tb_activation_stage;

    localparam int DW   = 8;
    localparam int N    = 4;
    localparam int W    = DW * N;
    localparam int MAXC = 4096;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         enable_activation;
    logic [1:0]   mode;
    logic [DW-1:0] clamp_max;
    logic [2:0]   leak_shift;
    logic [7:0]   num_rows;
    logic         in_data_available;
    logic [W-1:0] inp_data;
    logic [W-1:0] out_data;
    logic         out_data_available;
    logic         done_activation;
    logic         busy;

    activation_stage #(.DWIDTH(DW), .MAT_MUL_SIZE(N)) dut (
        .clk                (clk),
        .reset              (reset),
        .enable_activation  (enable_activation),
        .mode               (mode),
        .clamp_max          (clamp_max),
        .leak_shift         (leak_shift),
        .num_rows           (num_rows),
        .in_data_available  (in_data_available),
        .inp_data           (inp_data),
        .out_data           (out_data),
        .out_data_available (out_data_available),
        .done_activation    (done_activation),
        .busy               (busy)
    );

    // ---------------- scoreboard / model state ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit check_en = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] seen_q[$];
    bit exp_valid_at[MAXC];
    bit exp_done_at[MAXC];

    bit         mx_on = 1'b0;
    int         mx_start, mx_cnt, mx_target, mx_done;
    bit         m_en;
    logic [1:0] m_mode;
    int         m_clamp, m_shift;

    int valid_seen, done_seen;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Activation of one lane from the rules, using integer arithmetic.
    function automatic int lane_ref(input int x, input bit en, input logic [1:0] md,
                                    input int clampv, input int sh);
        int d, cm;
        if (!en || md == 2'b00) return x;
        if (md == 2'b01) return (x < 0) ? 0 : x;
        if (md == 2'b10) begin
            cm = (clampv < 0) ? 0 : clampv;
            if (x < 0) return 0;
            return (x < cm) ? x : cm;
        end
        d = 1 << sh;
        if (x < 0) return -((-x + d - 1) / d);  // floor(x / 2^sh)
        return x;
    endfunction

    function automatic logic [W-1:0] row_ref(input logic [W-1:0] r);
        logic [W-1:0]         o;
        logic signed [DW-1:0] l;
        int                   y;
        o = '0;
        for (int i = 0; i < N; i++) begin
            l = r[i*DW +: DW];
            y = lane_ref(int'(l), m_en, m_mode, m_clamp, m_shift);
            o[i*DW +: DW] = y[DW-1:0];
        end
        return o;
    endfunction

    function automatic logic [W-1:0] pack(input int a, input int b, input int c, input int d);
        logic [DW-1:0] a8, b8, c8, d8;
        a8 = a[DW-1:0];
        b8 = b[DW-1:0];
        c8 = c[DW-1:0];
        d8 = d[DW-1:0];
        return {d8, c8, b8, a8};
    endfunction

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input bit v, input logic [W-1:0] d);
        bit busy_exp;
        in_data_available = v;
        inp_data          = d;

        if (cyc + 4 >= MAXC) begin
            $display("FAIL cycle_budget observed=%0d limit=%0d", cyc, MAXC);
            $fatal(1);
        end

        if (mx_on && mx_done >= 0 && cyc > mx_done) mx_on = 1'b0;
        busy_exp = mx_on && (cyc > mx_start) && (mx_done < 0 || cyc < mx_done);

        if (check_en) begin
            chk("out_valid", {31'd0, out_data_available}, {31'd0, exp_valid_at[cyc]});
            if (out_data_available === 1'b1) begin
                valid_seen++;
                seen_q.push_back(out_data);
            end
            if (exp_valid_at[cyc] && exp_q.size() > 0) begin
                chk("out_data", out_data, exp_q.pop_front());
            end else if (!exp_valid_at[cyc]) begin
                chk("out_data_zero", out_data, '0);
            end
            chk("done", {31'd0, done_activation}, {31'd0, exp_done_at[cyc]});
            if (done_activation === 1'b1) done_seen++;
            chk("busy", {31'd0, busy}, {31'd0, busy_exp});
        end

        if (reset) begin
            exp_q.delete();
            for (int k = cyc + 1; k < MAXC; k++) begin
                exp_valid_at[k] = 1'b0;
                exp_done_at[k]  = 1'b0;
            end
            mx_on = 1'b0;
        end else if (v) begin
            if (!mx_on) begin
                mx_on     = 1'b1;
                mx_start  = cyc;
                mx_cnt    = 0;
                mx_done   = -1;
                mx_target = (num_rows == 8'd0) ? 256 : int'(num_rows);
                m_en      = enable_activation;
                m_mode    = mode;
                m_clamp   = int'($signed(clamp_max));
                m_shift   = int'(leak_shift);
            end
            if (mx_cnt < mx_target) begin
                mx_cnt++;
                exp_q.push_back(row_ref(d));
                exp_valid_at[cyc + 2] = 1'b1;
                if (mx_cnt == mx_target) begin
                    mx_done = cyc + 3;
                    exp_done_at[cyc + 3] = 1'b1;
                end
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom());
    endtask

    task automatic clear_obs();
        seen_q.delete();
        valid_seen = 0;
        done_seen  = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset             = 1'b1;
        enable_activation = 1'b1;
        mode              = 2'b01;
        clamp_max         = 8'd0;
        leak_shift        = 3'd0;
        num_rows          = 8'd4;
        in_data_available = 1'b0;
        inp_data          = '0;
        clear_obs();

        // Reset state: outputs are unknown before the first edge.
        step(1'b0, '0);
        check_en = 1'b1;
        step(1'b0, '0);
        reset = 1'b0;
        idle(2);

        // T1: reset with rows in flight.
        clear_obs();
        mode = 2'b01; num_rows = 8'd4;
        step(1'b1, pack(3, -3, 4, -4));
        step(1'b1, pack(5, 6, 7, 8));
        reset = 1'b1;
        step(1'b1, pack(1, 1, 1, 1));
        reset = 1'b0;
        chk("t1_out_after_reset", out_data, '0);
        chk("t1_busy_after_reset", {31'd0, busy}, 32'd0);
        idle(8);
        chk("t1_no_done", done_seen, 32'd0);
        chk("t1_valids", valid_seen, 32'd1);

        // T2: ReLU, four back-to-back rows.
        clear_obs();
        mode = 2'b01; num_rows = 8'd4;
        step(1'b1, pack(-5, 0, 7, -128));
        for (int i = 0; i < 3; i++) step(1'b1, $urandom());
        idle(6);
        chk("t2_row0", seen_q.size() > 0 ? seen_q[0] : 'x, pack(0, 0, 7, 0));
        chk("t2_valids", valid_seen, 32'd4);
        chk("t2_done", done_seen, 32'd1);

        // T3: clamped ReLU with positive and negative bound.
        clear_obs();
        mode = 2'b10; num_rows = 8'd1; clamp_max = 8'd6;
        step(1'b1, pack(10, 6, -1, 127));
        idle(5);
        clamp_max = 8'hFD;
        step(1'b1, pack(10, 6, -1, 127));
        idle(5);
        chk("t3_clamp6", seen_q.size() > 0 ? seen_q[0] : 'x, pack(6, 6, 0, 6));
        chk("t3_clamp_neg", seen_q.size() > 1 ? seen_q[1] : 'x, pack(0, 0, 0, 0));

        // T4: leaky ReLU, then the same row with activation disabled.
        clear_obs();
        mode = 2'b11; leak_shift = 3'd2; num_rows = 8'd1;
        step(1'b1, pack(-8, -1, -128, 5));
        idle(5);
        enable_activation = 1'b0;
        step(1'b1, pack(-8, -1, -128, 5));
        idle(5);
        enable_activation = 1'b1;
        chk("t4_leaky", seen_q.size() > 0 ? seen_q[0] : 'x, pack(-2, -1, -32, 5));
        chk("t4_bypass", seen_q.size() > 1 ? seen_q[1] : 'x, pack(-8, -1, -128, 5));

        // T5: mode changes mid-matrix are ignored; a row sent during DRAIN is dropped.
        clear_obs();
        mode = 2'b01; leak_shift = 3'd2; num_rows = 8'd3;
        step(1'b1, pack(-1, 2, -3, 4));
        step(1'b1, pack(9, -9, 9, -9));
        mode = 2'b11;
        step(1'b1, pack(-4, 9, -100, 1));
        step(1'b1, pack(-50, -50, -50, -50));
        idle(6);
        chk("t5_valids", valid_seen, 32'd3);
        chk("t5_row2", seen_q.size() > 2 ? seen_q[2] : 'x, pack(0, 9, 0, 1));
        chk("t5_done", done_seen, 32'd1);

        // T6: 256-row matrix, gapped and back-to-back mix.
        clear_obs();
        mode = 2'b11; leak_shift = 3'd1; num_rows = 8'd0;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, $urandom());
            step(1'b1, $urandom());
        end
        idle(6);
        chk("t6_valids", valid_seen, 32'd256);
        chk("t6_done", done_seen, 32'd1);

        // Random: configuration and strobe vary every cycle.
        for (int i = 0; i < 600; i++) begin
            enable_activation = $urandom_range(0, 7) != 0;
            mode              = 2'($urandom_range(0, 3));
            clamp_max         = 8'($urandom_range(0, 255));
            leak_shift        = 3'($urandom_range(0, 7));
            num_rows          = 8'($urandom_range(1, 6));
            step($urandom_range(0, 99) < 70, $urandom());
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
